// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the calculator display path.
// Imported by bin_to_bcd_seq and bcd_add3_digit.
package calc_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must reach BIN_W, hence the +1.
  function automatic int calc_iter_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a digit >= 5 gets +3 before the shift.
// Ports: i_digit (4b BCD digit in), o_digit (4b corrected digit out).
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5)
      o_digit = i_digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), start/done handshake.
// Ports: clk, reset (async high), start, bin_in -> busy, done (1-cycle),
//   bcd_out {thousands..ones}, overflow (saturated to 9s), neg.
// Macro SIGNED_MODE_EN: bin_in is two's complement and neg reports sign;
//   undefined: bin_in unsigned and neg is constant 0.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  neg
);

  // One spare digit on top catches values beyond DIGITS digits.
  localparam int SCR_W  = (DIGITS + 1) * BCD_DIGIT_W;
  localparam int OUT_W  = DIGITS * BCD_DIGIT_W;
  localparam int ITER_W = calc_iter_w(BIN_W);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [BIN_W-1:0]   r_shift;
  logic [SCR_W-1:0]   r_scr;
  logic [ITER_W-1:0]  r_iter;
  logic               r_sign;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_neg;

  logic [BIN_W-1:0]   w_mag;
  logic               w_sign;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_scr_nxt;
  logic               w_last;
  logic               w_top_nz;

`ifdef SIGNED_MODE_EN
  // Most-negative value negates to itself, which read
  // unsigned is exactly its magnitude 2^(BIN_W-1).
  assign w_sign = bin_in[BIN_W-1];
  assign w_mag  = w_sign ? (-bin_in) : bin_in;
`else
  assign w_sign = 1'b0;
  assign w_mag  = bin_in;
`endif

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_scr_nxt = {w_adj[SCR_W-2:0], r_shift[BIN_W-1]};
  assign w_last    = (r_iter == ITER_W'(BIN_W - 1));
  assign w_top_nz  = |w_scr_nxt[SCR_W-1 -: BCD_DIGIT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_scr   <= '0;
      r_iter  <= '0;
      r_sign  <= 1'b0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= w_mag;
            r_scr   <= '0;
            r_iter  <= '0;
            r_sign  <= w_sign;
          end
        end
        ST_SHIFT: begin
          r_scr   <= w_scr_nxt;
          r_shift <= r_shift << 1;
          r_iter  <= r_iter + ITER_W'(1);
          // Result lands with the final shift so it is
          // already valid in the cycle done is high.
          if (w_last) begin
            r_neg <= r_sign;
            if (w_top_nz) begin
              r_bcd <= {DIGITS{BCD_NINE}};
              r_ovf <= 1'b1;
            end else begin
              r_bcd <= w_scr_nxt[OUT_W-1:0];
              r_ovf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;
`ifdef SIGNED_MODE_EN
  assign neg      = r_neg;
`else
  assign neg      = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: scoreboard of expected
// results pushed at start, popped and compared on each done pulse.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;
  logic        neg;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {neg, overflow, bcd}.
  function automatic logic [17:0] model(input logic [15:0] v);
    int   mag;
    logic s;
    logic [15:0] b;
`ifdef SIGNED_MODE_EN
    s   = v[15];
    mag = s ? (65536 - int'(v)) : int'(v);
`else
    s   = 1'b0;
    mag = int'(v);
`endif
    if (mag > 9999) return {s, 1'b1, 16'h9999};
    b = {4'(mag / 1000), 4'((mag / 100) % 10),
         4'((mag / 10) % 10), 4'(mag % 10)};
    return {s, 1'b0, b};
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexp_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcd", 32'(bcd_out), 32'(mon_e[15:0]));
        chk("ovf", 32'(overflow), 32'(mon_e[16]));
        chk("neg", 32'(neg), 32'(mon_e[17]));
      end
    end
  end

  task automatic convert(input logic [15:0] v,
                         input int glitch_at,
                         input bit start_at_done);
    int n;
    int bcyc;
    int d0;
    bit seen;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(model(v));
    d0 = n_done;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    n = 1;
    bcyc = 0;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (busy) bcyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (n == glitch_at) begin
          start  = 1'b1;
          bin_in = v ^ 16'h5a5a;
        end else begin
          start  = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (seen && start_at_done) begin
      start  = 1'b1;
      bin_in = 16'd3;
    end
    chk("timeout", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'd17);
    chk("busy_cyc", 32'(bcyc), 32'd17);
    @(negedge clk);
    chk("n_done", 32'(n_done - d0), 32'd1);
    chk("idle", 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    reset = 1'b0;

    convert(16'd0, 0, 1'b0);
    convert(16'd255, 0, 1'b0);
    convert(16'd9999, 0, 1'b0);
    convert(16'd10000, 0, 1'b0);
    convert(16'd42, 0, 1'b0);
    convert(16'd777, 5, 1'b0);
    convert(16'd65535, 0, 1'b1);
    convert(16'd1, 0, 1'b0);

    // Abort mid-conversion with reset.
    @(negedge clk);
    bin_in = 16'd1234;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    begin
      int d0;
      d0 = n_done;
      repeat (25) @(negedge clk);
      chk("abort_nodone", 32'(n_done - d0), 32'd0);
    end
    convert(16'd1234, 0, 1'b0);

    convert(16'hFFD6, 0, 1'b0);
    convert(16'h8000, 0, 1'b0);
    convert(16'h7FFF, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      convert(16'($urandom_range(0, 20000)), 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
